// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter arbiter slice.
// Shift-type encoding, FSM state encoding and the captured-operation record.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int TYPE_W = 2;

    // Any non-zero type is a logical right shift; only LSL/LSR are named.
    localparam logic [TYPE_W-1:0] SH_LSL = 2'd0;
    localparam logic [TYPE_W-1:0] SH_LSR = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amount;
        logic [TYPE_W-1:0] sh_type;
        logic              id;
    } op_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two valid/ready request channels plus one tagged response channel.
// master = requesters/consumer side, slave = the arbiter.
interface shift_arbiter_if;
    import shift_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [AMT_W-1:0]  req0_amount;
    logic [TYPE_W-1:0] req0_type;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [AMT_W-1:0]  req1_amount;
    logic [TYPE_W-1:0] req1_type;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;

    modport master (
        output req0_valid, req0_data, req0_amount, req0_type,
        output req1_valid, req1_data, req1_amount, req1_type,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amount, req0_type,
        input  req1_valid, req1_data, req1_amount, req1_type,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 && (!req1 || last_grant);
    assign gnt1 = req1 && (!req0 || !last_grant);

endmodule

// File: rtl/shift.sv
// 32-bit logical shifter; combinational for non-zero amounts.
// For amount 0 it repeats its last non-zero result, so callers must bypass that case.
module shift
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amount,
    input  logic [TYPE_W-1:0] sh_type,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] held;

    always_comb begin
        shifted = data >> amount;
        if (sh_type == SH_LSL) begin
            shifted = data << amount;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (amount != '0) begin
            held <= shifted;
        end
    end

    assign result = (amount == '0) ? held : shifted;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter between two requesters; result returned tagged with requester id.
// Accept -> CALC -> RESP, 3 cycles per op, no overlap; requests stall outside IDLE, RESP holds until resp_ready.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    state_e            state;
    op_t               op_q;
    op_t               op_win;
    logic              last_grant;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [DATA_W-1:0] sh_out;
    logic [DATA_W-1:0] calc_result;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_id_q;

    rr_arbiter2 u_arb (
        .req0       (bus.req0_valid),
        .req1       (bus.req1_valid),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // Ready is combinational and only ever offered in IDLE, outside reset.
    assign bus.req0_ready = rst_n && (state == IDLE) && gnt0;
    assign bus.req1_ready = rst_n && (state == IDLE) && gnt1;
    assign accept = (bus.req0_valid && bus.req0_ready)
                 || (bus.req1_valid && bus.req1_ready);

    always_comb begin
        op_win.data    = bus.req0_data;
        op_win.amount  = bus.req0_amount;
        op_win.sh_type = bus.req0_type;
        op_win.id      = 1'b0;
        if (gnt1) begin
            op_win.data    = bus.req1_data;
            op_win.amount  = bus.req1_amount;
            op_win.sh_type = bus.req1_type;
            op_win.id      = 1'b1;
        end
    end

    shift u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (op_q.data),
        .amount  (op_q.amount),
        .sh_type (op_q.sh_type),
        .result  (sh_out)
    );

    // The shifter repeats stale output for a zero amount; pass the operand straight through.
    assign calc_result = (op_q.amount == '0) ? op_q.data : sh_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= '0;
            last_grant   <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_win;
                        last_grant <= op_win.id;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    resp_data_q  <= calc_result;
                    resp_id_q    <= op_q.id;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, latency, round-robin, zero-amount bypass, stall, mid-op reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid  = 1'b0;
        bus.req0_data   = '0;
        bus.req0_amount = '0;
        bus.req0_type   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_data   = '0;
        bus.req1_amount = '0;
        bus.req1_type   = '0;
        bus.resp_ready  = 1'b0;
    endtask

    task automatic set_req0(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
        bus.req0_valid  = 1'b1;
        bus.req0_data   = d;
        bus.req0_amount = a;
        bus.req0_type   = t;
    endtask

    task automatic set_req1(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
        bus.req1_valid  = 1'b1;
        bus.req1_data   = d;
        bus.req1_amount = a;
        bus.req1_type   = t;
    endtask

    // Waits (bounded) until a handshake is pending, then takes the accept edge.
    task automatic wait_accept(input string tag, output logic id);
        int n;
        n = 0;
        #1;
        while (!(bus.req0_valid && bus.req0_ready) && !(bus.req1_valid && bus.req1_ready) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_accept_timeout"}, 32'(n < 20), 32'd1);
        id = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic exp_id, input logic [31:0] exp_data,
                          input logic drop);
        logic id;
        wait_accept(tag, id);
        check({tag, "_grant_id"}, 32'(id), 32'(exp_id));
        if (drop) begin
            if (id) bus.req1_valid = 1'b0;
            else    bus.req0_valid = 1'b0;
        end
        #1;
        check({tag, "_calc_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_calc_rdy"}, 32'(bus.req0_ready || bus.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_resp_data"}, bus.resp_data, exp_data);
        check({tag, "_resp_id"}, 32'(bus.resp_id), 32'(exp_id));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({tag, "_after_valid"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        logic id;
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_resp_id", 32'(bus.resp_id), 32'd0);
        check("rst_rdy0", 32'(bus.req0_ready), 32'd0);
        check("rst_rdy1", 32'(bus.req1_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, left shift.
        set_req0(32'h0000_00F0, 5'd4, 2'd0);
        #1;
        check("t1_rdy0", 32'(bus.req0_ready), 32'd1);
        check("t1_rdy1", 32'(bus.req1_ready), 32'd0);
        run_op("t1", 1'b0, 32'h0000_0F00, 1'b1);

        // Tie straight after reset: req0 first, then req1.
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req0(32'h8000_0001, 5'd1, 2'd1);
        set_req1(32'h0000_0001, 5'd31, 2'd0);
        run_op("t2a", 1'b0, 32'h4000_0000, 1'b0);
        run_op("t2b", 1'b1, 32'h8000_0000, 1'b0);
        clear_inputs();

        // Both held valid: grants alternate.
        set_req0(32'h0000_0003, 5'd2, 2'd0);
        set_req1(32'hF000_0000, 5'd4, 2'd2);
        run_op("t3a", 1'b0, 32'h0000_000C, 1'b0);
        run_op("t3b", 1'b1, 32'h0F00_0000, 1'b0);
        run_op("t3c", 1'b0, 32'h0000_000C, 1'b0);
        run_op("t3d", 1'b1, 32'h0F00_0000, 1'b0);
        clear_inputs();

        // Zero amount must bypass the shifter's stale output.
        set_req0(32'h2468_ACF0, 5'd1, 2'd1);
        run_op("t4a", 1'b0, 32'h1234_5678, 1'b1);
        set_req0(32'hDEAD_BEEF, 5'd0, 2'd0);
        run_op("t4b", 1'b0, 32'hDEAD_BEEF, 1'b1);

        // Response stalled for 10 cycles while req1 waits.
        set_req0(32'h0000_0001, 5'd8, 2'd0);
        wait_accept("t5", id);
        check("t5_id", 32'(id), 32'd0);
        bus.req0_valid = 1'b0;
        set_req1(32'h0000_0080, 5'd7, 2'd3);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", 32'(bus.resp_valid), 32'd1);
            check("t5_hold_data", bus.resp_data, 32'h0000_0100);
            check("t5_hold_id", 32'(bus.resp_id), 32'd0);
            check("t5_hold_rdy1", 32'(bus.req1_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("t5_release_valid", 32'(bus.resp_valid), 32'd0);
        check("t5_release_rdy1", 32'(bus.req1_ready), 32'd1);
        run_op("t5b", 1'b1, 32'h0000_0001, 1'b1);

        // Reset during CALC discards the op and restores the tie winner.
        set_req0(32'h0000_0055, 5'd2, 2'd0);
        wait_accept("t6", id);
        check("t6_id", 32'(id), 32'd0);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t6_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        set_req0(32'h0000_0010, 5'd1, 2'd0);
        set_req1(32'h0000_0003, 5'd1, 2'd1);
        run_op("t6a", 1'b0, 32'h0000_0020, 1'b0);
        run_op("t6b", 1'b1, 32'h0000_0001, 1'b0);
        clear_inputs();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
